// File: rtl/sakebi_ipv4_packet_rx_if.sv
// sakebi_ipv4_packet_rx_if: byte-stream valid/ready/data bundle
interface sakebi_ipv4_packet_rx_if #(parameter int DATA_WIDTH = 8);
  logic TVALID;
  logic TREADY;
  logic [DATA_WIDTH-1:0] TDATA;
  modport master(output TVALID, output TDATA, input TREADY);
  modport slave(input TVALID, input TDATA, output TREADY);
endinterface

// File: rtl/sakebi_ipv4_packet_rx.sv
// sakebi_ipv4_packet_rx: parses/validates an IPv4 header from an Ethernet payload stream and forwards its payload
module sakebi_ipv4_packet_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int IP_ADDR_WIDTH = 32
) (
  input  logic                     i_axis_ACLK,
  input  logic                     i_axis_ARESET,
  sakebi_ipv4_packet_rx_if.slave   i_axis,
  sakebi_ipv4_packet_rx_if.master  o_axis,
  input  logic [15:0]              i_ethertype,
  input  logic                     i_specify_ip_en,
  input  logic [IP_ADDR_WIDTH-1:0] i_ip_addr,
  output logic [IP_ADDR_WIDTH-1:0] o_src_ip_addr,
  output logic [IP_ADDR_WIDTH-1:0] o_dst_ip_addr,
  output logic [7:0]               o_protocol,
  output logic [15:0]              o_total_length,
  output logic                     o_hdr_valid,
  output logic                     o_drop,
  output logic                     o_checksum_err,
  output logic                     o_truncated
);
  typedef enum logic [2:0] {IDLE, HEADER, OPTIONS, PAYLOAD, DROP} state_t;
  state_t state_q, state_d;
  logic [3:0] ihl_q, ihl_d;
  logic [7:0] cnt_q, cnt_d, proto_q, proto_d, oproto_q, oproto_d, td_q, td_d, b;
  logic [15:0] pay_q, pay_d, sum_q, sum_d, tlen_q, tlen_d, olen_q, olen_d;
  logic [IP_ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, osrc_q, osrc_d, odst_q, odst_d, dst_c;
  logic hv_q, hv_d, drop_q, drop_d, cerr_q, cerr_d, trunc_q, trunc_d, tv_q, tv_d;
  logic [15:0] hdr_len, addend, sum_c;
  logic [16:0] sum_w;
  logic tv, last_hdr, pass;
  assign b = i_axis.TDATA[7:0];
  assign tv = i_axis.TVALID;
  assign hdr_len = {10'd0, ihl_q, 2'b00};
  // Even-indexed header bytes are the high half of each 16-bit word
  assign addend = cnt_q[0] ? {8'h00, b} : {b, 8'h00};
  assign sum_w = {1'b0, sum_q} + {1'b0, addend};
  assign sum_c = sum_w[15:0] + {15'd0, sum_w[16]};
  assign dst_c = state_q == HEADER ? {dst_q[IP_ADDR_WIDTH-9:0], b} : dst_q;
  assign last_hdr = {8'd0, cnt_q} == hdr_len - 16'd1;
  assign pass = sum_c == 16'hFFFF && tlen_q >= hdr_len && (!i_specify_ip_en || dst_c == i_ip_addr);
  always_comb begin
    state_d = state_q;
    ihl_d = ihl_q;
    cnt_d = cnt_q;
    pay_d = pay_q;
    sum_d = sum_q;
    tlen_d = tlen_q;
    proto_d = proto_q;
    src_d = src_q;
    dst_d = dst_q;
    osrc_d = osrc_q;
    odst_d = odst_q;
    oproto_d = oproto_q;
    olen_d = olen_q;
    td_d = td_q;
    tv_d = 1'b0;
    hv_d = 1'b0;
    drop_d = 1'b0;
    cerr_d = 1'b0;
    trunc_d = 1'b0;
    case (state_q)
      IDLE: if (tv) begin
        if (i_ethertype != 16'h0800 || b[7:4] != 4'd4 || b[3:0] < 4'd5) begin
          state_d = DROP;
          drop_d = 1'b1;
        end else begin
          ihl_d = b[3:0];
          cnt_d = 8'd1;
          sum_d = {b, 8'h00};
          state_d = HEADER;
        end
      end
      HEADER, OPTIONS: if (!tv) begin
        state_d = IDLE;
        drop_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
        sum_d = sum_c;
        if (state_q == HEADER) begin
          tlen_d = cnt_q == 8'd2 ? {b, tlen_q[7:0]} : cnt_q == 8'd3 ? {tlen_q[15:8], b} : tlen_q;
          proto_d = cnt_q == 8'd9 ? b : proto_q;
          src_d = cnt_q >= 8'd12 && cnt_q <= 8'd15 ? {src_q[IP_ADDR_WIDTH-9:0], b} : src_q;
          dst_d = cnt_q >= 8'd16 && cnt_q <= 8'd19 ? dst_c : dst_q;
        end
        if (last_hdr && pass) begin
          osrc_d = src_q;
          odst_d = dst_c;
          oproto_d = proto_q;
          olen_d = tlen_q;
          hv_d = 1'b1;
          pay_d = tlen_q - hdr_len;
          state_d = tlen_q == hdr_len ? DROP : PAYLOAD;
        end else if (last_hdr) begin
          drop_d = 1'b1;
          cerr_d = sum_c != 16'hFFFF;
          state_d = DROP;
        end else if (cnt_q == 8'd19) state_d = OPTIONS;
      end
      PAYLOAD: if (!tv) begin
        state_d = IDLE;
        trunc_d = 1'b1;
      end else begin
        tv_d = 1'b1;
        td_d = b;
        pay_d = pay_q - 16'd1;
        state_d = pay_q == 16'd1 ? DROP : PAYLOAD;
      end
      DROP: state_d = tv ? DROP : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_axis_ACLK) begin
    if (i_axis_ARESET) begin
      state_q <= IDLE;
      ihl_q <= '0;
      cnt_q <= '0;
      pay_q <= '0;
      sum_q <= '0;
      tlen_q <= '0;
      proto_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      osrc_q <= '0;
      odst_q <= '0;
      oproto_q <= '0;
      olen_q <= '0;
      td_q <= '0;
      tv_q <= 1'b0;
      hv_q <= 1'b0;
      drop_q <= 1'b0;
      cerr_q <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ihl_q <= ihl_d;
      cnt_q <= cnt_d;
      pay_q <= pay_d;
      sum_q <= sum_d;
      tlen_q <= tlen_d;
      proto_q <= proto_d;
      src_q <= src_d;
      dst_q <= dst_d;
      osrc_q <= osrc_d;
      odst_q <= odst_d;
      oproto_q <= oproto_d;
      olen_q <= olen_d;
      td_q <= td_d;
      tv_q <= tv_d;
      hv_q <= hv_d;
      drop_q <= drop_d;
      cerr_q <= cerr_d;
      trunc_q <= trunc_d;
    end
  end
  assign i_axis.TREADY = ~i_axis_ARESET;
  assign o_axis.TVALID = tv_q;
  assign o_axis.TDATA = td_q;
  assign o_src_ip_addr = osrc_q;
  assign o_dst_ip_addr = odst_q;
  assign o_protocol = oproto_q;
  assign o_total_length = olen_q;
  assign o_hdr_valid = hv_q;
  assign o_drop = drop_q;
  assign o_checksum_err = cerr_q;
  assign o_truncated = trunc_q;
endmodule
